// File: rtl/ahb_apb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_apb_pkg
// Shared types and constants for the AHB-Lite to APB3 bridge:
//   htrans_e       - AHB transfer type encoding
//   HRESP_*        - AHB response codes
//   bridge_state_e - bridge FSM states
//   HSIZE_WORD     - widest transfer size the bridge forwards (32-bit)
// ---------------------------------------------------------------------------
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } bridge_state_e;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Only NONSEQ and SEQ beats carry a real transfer.
  function automatic logic is_active_trans(input htrans_e t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb2apb_addr_decode.sv
// ---------------------------------------------------------------------------
// ahb2apb_addr_decode
// Purely combinational slave decoder.
//   idx_i          - slave index taken from the upper address bits
//   psel_o         - one-hot select for the addressed slave (zero if none)
//   out_of_range_o - index does not map to an existing slave
// ---------------------------------------------------------------------------
module ahb2apb_addr_decode #(
  parameter int NUM_SLAVES = 4,
  parameter int IDX_W      = 20
) (
  input  logic [IDX_W-1:0]      idx_i,
  output logic [NUM_SLAVES-1:0] psel_o,
  output logic                  out_of_range_o
);

  // Comparisons are done at 33 bits so that a narrow index field never
  // truncates the slave count and aliases onto a valid slave.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
      assign psel_o[gi] = (33'(idx_i) == 33'(gi));
    end
  endgenerate

  assign out_of_range_o = (33'(idx_i) >= 33'(NUM_SLAVES));

endmodule

// File: rtl/ahb2apb_bridge.sv
// ---------------------------------------------------------------------------
// ahb2apb_bridge
// AHB-Lite slave to APB3 master bridge. Each accepted AHB beat becomes one
// APB SETUP/ACCESS transfer; the AHB data phase is stretched with hreadyout.
// Ports:
//   hclk, hresetn        - clock, asynchronous active-low reset
//   hsel..hwdata         - AHB-Lite slave inputs (hburst is ignored)
//   hreadyout/hresp/hrdata - AHB-Lite slave response
//   paddr..penable       - APB3 master request, psel one-hot per slave
//   prdata/pready/pslverr - APB3 completion
// ---------------------------------------------------------------------------
module ahb2apb_bridge #(
  parameter int NUM_SLAVES   = 4,
  parameter int SLV_ADDR_LSB = 12
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [31:0]           haddr,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [1:0]            htrans,
  input  logic                  hreadyin,
  input  logic [31:0]           hwdata,
  output logic                  hreadyout,
  output logic [1:0]            hresp,
  output logic [31:0]           hrdata,
  output logic [31:0]           paddr,
  output logic                  pwrite,
  output logic [31:0]           pwdata,
  output logic [NUM_SLAVES-1:0] psel,
  output logic                  penable,
  input  logic [31:0]           prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  import ahb_apb_pkg::*;

  localparam int IDX_W = 32 - SLV_ADDR_LSB;

  bridge_state_e         state_q, state_d;
  logic [31:0]           paddr_q;
  logic                  pwrite_q;
  logic [31:0]           pwdata_q;
  logic [31:0]           hrdata_q;
  logic [NUM_SLAVES-1:0] sel_q;

  logic [NUM_SLAVES-1:0] sel_dec;
  logic                  out_of_range;
  logic                  can_accept;
  logic                  accept;
  logic                  illegal;

  // Every beat is handled on its own, so the burst type carries no information.
  logic unused_hburst;
  assign unused_hburst = ^hburst;

  ahb2apb_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .IDX_W      (IDX_W)
  ) u_decode (
    .idx_i          (haddr[31:SLV_ADDR_LSB]),
    .psel_o         (sel_dec),
    .out_of_range_o (out_of_range)
  );

  // A new address phase can only be taken while hreadyout is high, i.e. in
  // the states that end a data phase (or have none pending).
  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_DONE) ||
                      (state_q == ST_ERR2);
  assign accept     = can_accept & hsel & hreadyin &
                      is_active_trans(htrans_e'(htrans));
  assign illegal    = out_of_range | (hsize > HSIZE_WORD);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (accept) begin
          if (illegal) begin
            state_d = ST_ERR1;
          end else if (hwrite) begin
            state_d = ST_WDATA;
          end else begin
            state_d = ST_SETUP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WDATA:  state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        // Slave error wins over a clean completion when both arrive together.
        if (pready) begin
          state_d = pslverr ? ST_ERR1 : ST_DONE;
        end
      end
      ST_ERR1:   state_d = ST_ERR2;
      default:   state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs (pure function of state so reset takes effect at once)
  // -------------------------------------------------------------------------
  always_comb begin
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    psel      = '0;
    penable   = 1'b0;
    unique case (state_q)
      ST_WDATA: begin
        hreadyout = 1'b0;
      end
      ST_SETUP: begin
        hreadyout = 1'b0;
        psel      = sel_q;
      end
      ST_ACCESS: begin
        hreadyout = 1'b0;
        psel      = sel_q;
        penable   = 1'b1;
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
      end
      ST_ERR2: begin
        hresp     = HRESP_ERROR;
      end
      default: begin
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      hrdata_q <= '0;
      sel_q    <= '0;
    end else begin
      if (accept) begin
        paddr_q  <= haddr;
        pwrite_q <= hwrite;
        // An error beat never reaches APB, so keep its select vector empty.
        sel_q    <= illegal ? '0 : sel_dec;
      end
      // hwdata belongs to the data phase, which is the WDATA cycle.
      if (state_q == ST_WDATA) begin
        pwdata_q <= hwdata;
      end
      // Read data is captured even on a slave error.
      if ((state_q == ST_ACCESS) && pready && !pwrite_q) begin
        hrdata_q <= prdata;
      end
    end
  end

  assign paddr  = paddr_q;
  assign pwrite = pwrite_q;
  assign pwdata = pwdata_q;
  assign hrdata = hrdata_q;

endmodule
